// File: rtl/sync_fifo_ctrl.sv
// FIFO controller wrapping a dual-port SRAM (write port A, registered read port B).
// Owns the pointers, occupancy flags, error pulses and the one-cycle read handshake.
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  mem_csen_n,
    output logic [ADDR_WIDTH-1:0] mem_addra,
    output logic [DATA_WIDTH-1:0] mem_data_a,
    output logic                  mem_wrena_n,
    output logic [ADDR_WIDTH-1:0] mem_addrb,
    output logic                  mem_rdenb_n,
    input  logic [DATA_WIDTH-1:0] mem_data_b
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

    // Gating with rst_n keeps the SRAM idle while reset is held.
    assign w_wr_acc = rst_n & wr_en & ~w_full;
    assign w_rd_acc = rst_n & rd_en & ~w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= wr_en & w_full;
            r_underflow <= rd_en & w_empty;
        end
    end

    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_wr_ptr - r_rd_ptr;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign rd_valid  = r_rd_valid;
    // The SRAM already registers its output, so the data is passed straight through.
    assign rd_data   = mem_data_b;

    assign mem_wrena_n = ~w_wr_acc;
    assign mem_addra   = r_wr_ptr[ADDR_WIDTH-1:0];
    assign mem_data_a  = wr_data;
    assign mem_rdenb_n = ~w_rd_acc;
    assign mem_addrb   = r_rd_ptr[ADDR_WIDTH-1:0];
    assign mem_csen_n  = ~(w_wr_acc | w_rd_acc);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: behavioural SRAM, queue-based reference FIFO and
// a read-data scoreboard popped by an independent monitor.
module tb_sync_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          mem_csen_n;
    logic [AW-1:0] mem_addra;
    logic [DW-1:0] mem_data_a;
    logic          mem_wrena_n;
    logic [AW-1:0] mem_addrb;
    logic          mem_rdenb_n;
    logic [DW-1:0] mem_data_b = '0;

    logic [DW-1:0] sram [DEPTH];

    int checks = 0;
    int errors = 0;
    bit checking_on = 1'b0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_rdv = 1'b0;
    logic          exp_ovf = 1'b0;
    logic          exp_udf = 1'b0;
    logic [DW-1:0] mon_exp;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .mem_csen_n  (mem_csen_n),
        .mem_addra   (mem_addra),
        .mem_data_a  (mem_data_a),
        .mem_wrena_n (mem_wrena_n),
        .mem_addrb   (mem_addrb),
        .mem_rdenb_n (mem_rdenb_n),
        .mem_data_b  (mem_data_b)
    );

    // Dual-port SRAM with registered read data
    always @(posedge clk) begin
        if (!mem_csen_n) begin
            if (!mem_wrena_n) sram[mem_addra] <= mem_data_a;
            if (!mem_rdenb_n) mem_data_b <= sram[mem_addrb];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check pre-edge outputs, advance the model.
    task automatic step(input logic rst, input logic we, input logic [DW-1:0] wd, input logic re);
        bit m_full;
        bit m_empty;
        bit wacc;
        bit racc;
        @(negedge clk);
        rst_n   = rst;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        #1;
        m_full  = (model_q.size() == DEPTH);
        m_empty = (model_q.size() == 0);
        wacc    = rst && we && !m_full;
        racc    = rst && re && !m_empty;
        if (checking_on) begin
            chk("count", int'(count), model_q.size());
            chk("full", int'(full), int'(m_full));
            chk("empty", int'(empty), int'(m_empty));
            chk("rd_valid", int'(rd_valid), int'(exp_rdv));
            chk("overflow", int'(overflow), int'(exp_ovf));
            chk("underflow", int'(underflow), int'(exp_udf));
            chk("mem_wrena_n", int'(mem_wrena_n), int'(!wacc));
            chk("mem_rdenb_n", int'(mem_rdenb_n), int'(!racc));
            chk("mem_csen_n", int'(mem_csen_n), int'(!(wacc || racc)));
            if (wacc) chk("mem_data_a", int'(mem_data_a), int'(wd));
        end
        exp_ovf = rst && we && m_full;
        exp_udf = rst && re && m_empty;
        exp_rdv = racc;
        if (!rst) begin
            model_q.delete();
        end else begin
            if (racc) exp_q.push_back(model_q.pop_front());
            if (wacc) model_q.push_back(wd);
        end
    endtask

    // Monitor: every presented read word is matched against the scoreboard.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data unexpected_valid actual=%0h expected=none t=%0t", rd_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("read rd_data=%0h expected=%0h t=%0t", rd_data, mon_exp, $time);
                chk("rd_data", int'(rd_data), int'(mon_exp));
            end
        end
    end

    initial begin
        int pw;
        int pr;
        // Reset then idle
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        checking_on = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);

        // Three writes, three reads
        step(1'b1, 1'b1, 8'h11, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0, 1'b0);

        // Fill to full, overflow attempt, read back
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, DW'(i), 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'hDD, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);

        // Underflow, then simultaneous access on empty
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'h5A, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);

        // Wrap-around at count 8
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, DW'(8'h80 + i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, DW'($urandom), 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);

        // Reset at count 5 with a read in flight
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, DW'(8'h40 + i), 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 8'h77, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 8'hA5, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);

        // Randomised traffic with shifting bias and occasional resets
        for (int blk = 0; blk < 8; blk++) begin
            pw = $urandom_range(20, 90);
            pr = $urandom_range(20, 90);
            for (int i = 0; i < 60; i++) begin
                step(($urandom_range(0, 99) != 0),
                     ($urandom_range(0, 99) < pw),
                     DW'($urandom),
                     ($urandom_range(0, 99) < pr));
            end
        end

        // Drain
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
